// File: rtl/cache_op_sequencer.sv
// cache_op_sequencer
// Runs one trace command at a time through the L2 tag/state array. Each
// command does a set lookup, selects a hit or victim way, runs any bus
// transactions, evaluates MESIF through the external mesif unit and writes
// the tag, state and PLRU back. The block also answers snoops and clears
// the whole cache.
//
// Optional feature macro: CACHE_STATS_EN adds the st_* statistic counters.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_opr, cmd_tag, cmd_index fields
//   arr_rd_en, arr_addr        set read; arr_rd_tag/state/lru return the next cycle
//   arr_wr_*                   array write at arr_addr (arr_wr_all clears a set)
//   mi_state/opr/snoop_in      operands to the mesif unit
//   mi_next_state/bus_op/snoop_out   combinational mesif results
//   bus_req/bus_op/bus_ack/bus_snoop bus transaction
//   snoop_rsp_valid, snoop_rsp response to a snooped command
//   done                       one-cycle pulse when a command retires
//   st_reads/writes/hits/misses  (CACHE_STATS_EN only) wrapping counters
module cache_op_sequencer #(
    parameter int TAG_BITS   = 12,
    parameter int INDEX_BITS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_opr,
    input  logic [TAG_BITS-1:0]   cmd_tag,
    input  logic [INDEX_BITS-1:0] cmd_index,
    output logic                  arr_rd_en,
    output logic [INDEX_BITS-1:0] arr_addr,
    input  logic [4*TAG_BITS-1:0] arr_rd_tag,
    input  logic [11:0]           arr_rd_state,
    input  logic [2:0]            arr_rd_lru,
    output logic                  arr_wr_en,
    output logic                  arr_wr_all,
    output logic [1:0]            arr_wr_way,
    output logic [TAG_BITS-1:0]   arr_wr_tag,
    output logic [2:0]            arr_wr_state,
    output logic [2:0]            arr_wr_lru,
    output logic [2:0]            mi_state,
    output logic [3:0]            mi_opr,
    output logic [1:0]            mi_snoop_in,
    input  logic [2:0]            mi_next_state,
    input  logic [2:0]            mi_bus_op,
    input  logic [1:0]            mi_snoop_out,
    output logic                  bus_req,
    output logic [2:0]            bus_op,
    input  logic                  bus_ack,
    input  logic [1:0]            bus_snoop,
    output logic                  snoop_rsp_valid,
    output logic [1:0]            snoop_rsp,
    output logic                  done
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           st_reads,
    output logic [31:0]           st_writes,
    output logic [31:0]           st_hits,
    output logic [31:0]           st_misses
`endif
);

    localparam logic [2:0] ST_M = 3'd0;
    localparam logic [2:0] ST_I = 3'd3;
    localparam logic [2:0] BOP_READ  = 3'd1;
    localparam logic [2:0] BOP_WRITE = 3'd2;
    localparam logic [2:0] BOP_RFO   = 3'd4;
    localparam logic [2:0] BOP_NOP   = 3'd5;
    localparam logic [1:0] SNP_HIT   = 2'd0;
    localparam logic [1:0] SNP_NOHIT = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_CMP, S_WB, S_BUS, S_EVAL, S_PBUS, S_UPD, S_CLR
    } state_t;

    state_t                  r_state, w_next;
    logic [3:0]              r_opr;
    logic [TAG_BITS-1:0]     r_tag;
    logic [INDEX_BITS-1:0]   r_index;
    logic                    r_hit;
    logic [1:0]              r_way;
    logic [2:0]              r_way_state;
    logic [2:0]              r_lru;
    logic [1:0]              r_snoop;
    logic [2:0]              r_next_state;
    logic [2:0]              r_mi_bus_op;
    logic [1:0]              r_mi_snoop;
    logic                    r_no_write;
    logic                    r_ackd;
    logic [INDEX_BITS-1:0]   r_clr_cnt;

    logic                    w_cpu_op, w_snoop_op;
    logic                    w_hit, w_inv_found;
    logic [1:0]              w_hit_way, w_inv_way, w_plru_way, w_sel_way;
    logic [2:0]              w_states [4];
    logic [2:0]              w_sel_state;

    // Touching a way points the PLRU tree away from it.
    function automatic logic [2:0] plru_touch(input logic [2:0] lru, input logic [1:0] way);
        logic [2:0] n;
        n    = lru;
        n[0] = ~way[1];
        if (!way[1]) n[1] = ~way[0];
        else         n[2] = ~way[0];
        return n;
    endfunction

    assign w_cpu_op   = (r_opr <= 4'd2);
    assign w_snoop_op = (r_opr >= 4'd3) && (r_opr <= 4'd6);

    // Lookup of the set returned by the array. Scanning from way 3 down
    // lets the lowest matching or invalid way win.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = 2'd0;
        w_inv_found = 1'b0;
        w_inv_way   = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            w_states[w] = arr_rd_state[3*w +: 3];
            if (w_states[w] != ST_I && arr_rd_tag[TAG_BITS*w +: TAG_BITS] == r_tag) begin
                w_hit     = 1'b1;
                w_hit_way = 2'(w);
            end
            if (w_states[w] == ST_I) begin
                w_inv_found = 1'b1;
                w_inv_way   = 2'(w);
            end
        end
        w_plru_way  = arr_rd_lru[0] ? (arr_rd_lru[2] ? 2'd3 : 2'd2)
                                    : (arr_rd_lru[1] ? 2'd1 : 2'd0);
        w_sel_way   = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_plru_way);
        w_sel_state = w_states[w_sel_way];
    end

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and all outputs decode from the current state, so reset
    // drops bus_req and arr_wr_en immediately. Bus states hold bus_req
    // until the ack, then spend one low cycle before moving on.
    always_comb begin
        w_next          = r_state;
        cmd_ready       = 1'b0;
        arr_rd_en       = 1'b0;
        arr_addr        = '0;
        arr_wr_en       = 1'b0;
        arr_wr_all      = 1'b0;
        arr_wr_way      = 2'd0;
        arr_wr_tag      = '0;
        arr_wr_state    = 3'd0;
        arr_wr_lru      = 3'd0;
        mi_state        = 3'd0;
        mi_opr          = 4'd0;
        mi_snoop_in     = 2'd0;
        bus_req         = 1'b0;
        bus_op          = 3'd0;
        snoop_rsp_valid = 1'b0;
        snoop_rsp       = 2'd0;
        done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_opr == 4'd8)      w_next = S_CLR;
                    else if (cmd_opr <= 4'd6) w_next = S_RD;
                    else                      w_next = S_UPD;
                end
            end
            S_RD: begin
                arr_rd_en = 1'b1;
                arr_addr  = r_index;
                w_next    = S_CMP;
            end
            S_CMP: begin
                arr_addr = r_index;
                if (w_hit)                  w_next = S_EVAL;
                else if (!w_cpu_op)         w_next = S_UPD;
                else if (w_sel_state == ST_M) w_next = S_WB;
                else                        w_next = S_BUS;
            end
            S_WB: begin
                bus_req = !r_ackd;
                bus_op  = BOP_WRITE;
                if (r_ackd) w_next = S_BUS;
            end
            S_BUS: begin
                bus_req  = !r_ackd;
                bus_op   = (r_opr == 4'd1) ? BOP_RFO : BOP_READ;
                mi_state = ST_I;
                if (r_ackd) w_next = S_EVAL;
            end
            S_EVAL: begin
                mi_state    = r_hit ? r_way_state : ST_I;
                mi_opr      = r_opr;
                mi_snoop_in = r_snoop;
                w_next      = (r_hit && mi_bus_op != BOP_NOP) ? S_PBUS : S_UPD;
            end
            S_PBUS: begin
                bus_req = !r_ackd;
                bus_op  = r_mi_bus_op;
                if (r_ackd) w_next = S_UPD;
            end
            S_UPD: begin
                arr_addr = r_index;
                if (!r_no_write) begin
                    arr_wr_en    = 1'b1;
                    arr_wr_way   = r_way;
                    arr_wr_tag   = r_tag;
                    arr_wr_state = r_next_state;
                    arr_wr_lru   = w_cpu_op ? plru_touch(r_lru, r_way) : r_lru;
                end
                if (w_snoop_op) begin
                    snoop_rsp_valid = 1'b1;
                    snoop_rsp       = r_hit ? r_mi_snoop : SNP_NOHIT;
                end
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_CLR: begin
                arr_wr_en  = 1'b1;
                arr_wr_all = 1'b1;
                arr_addr   = r_clr_cnt;
                if (r_clr_cnt == '1) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command fields, lookup results, bus capture and mesif results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opr        <= 4'd0;
            r_tag        <= '0;
            r_index      <= '0;
            r_hit        <= 1'b0;
            r_way        <= 2'd0;
            r_way_state  <= 3'd0;
            r_lru        <= 3'd0;
            r_snoop      <= SNP_HIT;
            r_next_state <= 3'd0;
            r_mi_bus_op  <= 3'd0;
            r_mi_snoop   <= 2'd0;
            r_no_write   <= 1'b0;
            r_ackd       <= 1'b0;
            r_clr_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_opr      <= cmd_opr;
                    r_tag      <= cmd_tag;
                    r_index    <= cmd_index;
                    r_hit      <= 1'b0;
                    r_snoop    <= SNP_HIT;
                    r_no_write <= (cmd_opr > 4'd6);
                    r_ackd     <= 1'b0;
                    r_clr_cnt  <= '0;
                end
                S_CMP: begin
                    r_hit       <= w_hit;
                    r_way       <= w_sel_way;
                    r_way_state <= w_sel_state;
                    r_lru       <= arr_rd_lru;
                    if (!w_cpu_op && !w_hit) r_no_write <= 1'b1;
                end
                S_WB, S_BUS, S_PBUS: begin
                    if (!r_ackd && bus_ack) begin
                        r_ackd <= 1'b1;
                        if (r_state == S_BUS) r_snoop <= bus_snoop;
                    end else if (r_ackd) begin
                        r_ackd <= 1'b0;
                    end
                end
                S_EVAL: begin
                    r_next_state <= mi_next_state;
                    r_mi_bus_op  <= mi_bus_op;
                    r_mi_snoop   <= mi_snoop_out;
                end
                S_CLR: r_clr_cnt <= r_clr_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_st_reads, r_st_writes, r_st_hits, r_st_misses;

    // Statistics retire with the command; a clear command zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_reads  <= 32'd0;
            r_st_writes <= 32'd0;
            r_st_hits   <= 32'd0;
            r_st_misses <= 32'd0;
        end else if (r_state == S_IDLE && cmd_valid && cmd_opr == 4'd8) begin
            r_st_reads  <= 32'd0;
            r_st_writes <= 32'd0;
            r_st_hits   <= 32'd0;
            r_st_misses <= 32'd0;
        end else if (r_state == S_UPD && w_cpu_op) begin
            if (r_opr == 4'd1) r_st_writes <= r_st_writes + 32'd1;
            else               r_st_reads  <= r_st_reads + 32'd1;
            if (r_hit)         r_st_hits   <= r_st_hits + 32'd1;
            else               r_st_misses <= r_st_misses + 32'd1;
        end
    end

    assign st_reads  = r_st_reads;
    assign st_writes = r_st_writes;
    assign st_hits   = r_st_hits;
    assign st_misses = r_st_misses;
`endif

endmodule

// File: tb/tb_cache_op_sequencer.sv
// Testbench for cache_op_sequencer with a 4-set array model, a bus responder
// and a mesif stand-in that only answers the operands each vector expects.
module tb_cache_op_sequencer;

    localparam int TB = 12;
    localparam int IB = 2;
    localparam logic [2:0] SM = 3'd0, SE = 3'd1, SS = 3'd2, SI = 3'd3, SF = 3'd4;

    typedef struct packed {
        logic [3:0]  opr;
        logic [11:0] tag;
        logic [1:0]  idx;
        logic [47:0] preTags;
        logic [11:0] preStates;
        logic [2:0]  preLru;
        logic [1:0]  snoop;
        logic [2:0]  expMiState;
        logic [1:0]  expMiSnoopIn;
        logic [2:0]  miNs;
        logic [2:0]  miBop;
        logic [1:0]  miSo;
        logic        expWr;
        logic [1:0]  expWay;
        logic [2:0]  expState;
        logic [2:0]  expLru;
        logic [1:0]  expNBus;
        logic [2:0]  expBus0;
        logic [2:0]  expBus1;
        logic        expRspV;
        logic [1:0]  expRsp;
        logic [7:0]  expCyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [3:0] cmd_opr = 4'd0;
    logic [TB-1:0] cmd_tag = '0;
    logic [IB-1:0] cmd_index = '0;
    logic arr_rd_en;
    logic [IB-1:0] arr_addr;
    logic [4*TB-1:0] arr_rd_tag = '0;
    logic [11:0] arr_rd_state = '0;
    logic [2:0] arr_rd_lru = '0;
    logic arr_wr_en, arr_wr_all;
    logic [1:0] arr_wr_way;
    logic [TB-1:0] arr_wr_tag;
    logic [2:0] arr_wr_state, arr_wr_lru;
    logic [2:0] mi_state;
    logic [3:0] mi_opr;
    logic [1:0] mi_snoop_in;
    logic [2:0] mi_next_state, mi_bus_op;
    logic [1:0] mi_snoop_out;
    logic bus_req;
    logic [2:0] bus_op;
    logic bus_ack = 1'b0;
    logic [1:0] bus_snoop = 2'd0;
    logic snoop_rsp_valid;
    logic [1:0] snoop_rsp;
    logic done;
`ifdef CACHE_STATS_EN
    logic [31:0] st_reads, st_writes, st_hits, st_misses;
`endif

    cache_op_sequencer #(.TAG_BITS(TB), .INDEX_BITS(IB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opr(cmd_opr), .cmd_tag(cmd_tag), .cmd_index(cmd_index),
        .arr_rd_en(arr_rd_en), .arr_addr(arr_addr),
        .arr_rd_tag(arr_rd_tag), .arr_rd_state(arr_rd_state), .arr_rd_lru(arr_rd_lru),
        .arr_wr_en(arr_wr_en), .arr_wr_all(arr_wr_all), .arr_wr_way(arr_wr_way),
        .arr_wr_tag(arr_wr_tag), .arr_wr_state(arr_wr_state), .arr_wr_lru(arr_wr_lru),
        .mi_state(mi_state), .mi_opr(mi_opr), .mi_snoop_in(mi_snoop_in),
        .mi_next_state(mi_next_state), .mi_bus_op(mi_bus_op), .mi_snoop_out(mi_snoop_out),
        .bus_req(bus_req), .bus_op(bus_op), .bus_ack(bus_ack), .bus_snoop(bus_snoop),
        .snoop_rsp_valid(snoop_rsp_valid), .snoop_rsp(snoop_rsp), .done(done)
`ifdef CACHE_STATS_EN
        , .st_reads(st_reads), .st_writes(st_writes), .st_hits(st_hits), .st_misses(st_misses)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Values the mesif stand-in answers with, set per vector.
    logic [2:0] curMiState = 3'd0;
    logic [3:0] curOpr = 4'd0;
    logic [1:0] curMiSnoop = 2'd0;
    logic [2:0] curNs = 3'd0, curBop = 3'd5;
    logic [1:0] curSo = 2'd0;

    // A wrong operand gets a poison answer so it shows up in the write-back.
    always_comb begin
        if (mi_state == curMiState && mi_opr == curOpr && mi_snoop_in == curMiSnoop) begin
            mi_next_state = curNs;
            mi_bus_op     = curBop;
            mi_snoop_out  = curSo;
        end else begin
            mi_next_state = 3'd6;
            mi_bus_op     = 3'd6;
            mi_snoop_out  = 2'd3;
        end
    end

    // Array model, bus responder and event logs, all updated mid-cycle.
    logic [TB-1:0] mTag [0:3][0:3];
    logic [2:0] mState [0:3][0:3];
    logic [2:0] mLru [0:3];
    logic initDone = 1'b0;
    int preloadSeq = 0, appliedSeq = 0;
    vec_t pVec;
    int wrCount = 0, rspCount = 0, doneCount = 0, busCount = 0, clrCount = 0, busWait = 0;
    logic [1:0] wrWay;
    logic [TB-1:0] wrTag;
    logic [2:0] wrState, wrLru;
    logic [1:0] rspVal;
    logic [2:0] busLog [0:63];
    logic [IB-1:0] clrAddrs [0:15];

    always @(negedge clk) begin
        if (!initDone) begin
            for (int s = 0; s < 4; s++) begin
                for (int w = 0; w < 4; w++) begin
                    mTag[s][w]   = '0;
                    mState[s][w] = SI;
                end
                mLru[s] = 3'd0;
            end
            initDone = 1'b1;
        end
        if (preloadSeq != appliedSeq) begin
            for (int w = 0; w < 4; w++) begin
                mTag[pVec.idx][w]   = pVec.preTags[w*12 +: 12];
                mState[pVec.idx][w] = pVec.preStates[w*3 +: 3];
            end
            mLru[pVec.idx] = pVec.preLru;
            appliedSeq = preloadSeq;
        end
        if (arr_rd_en) begin
            for (int w = 0; w < 4; w++) begin
                arr_rd_tag[w*TB +: TB] = mTag[arr_addr][w];
                arr_rd_state[w*3 +: 3] = mState[arr_addr][w];
            end
            arr_rd_lru = mLru[arr_addr];
        end
        if (arr_wr_en) begin
            if (arr_wr_all) begin
                for (int w = 0; w < 4; w++) mState[arr_addr][w] = SI;
                mLru[arr_addr] = 3'd0;
                if (clrCount < 16) clrAddrs[clrCount] = arr_addr;
                clrCount++;
            end else begin
                mTag[arr_addr][arr_wr_way]   = arr_wr_tag;
                mState[arr_addr][arr_wr_way] = arr_wr_state;
                mLru[arr_addr]               = arr_wr_lru;
                wrWay = arr_wr_way; wrTag = arr_wr_tag; wrState = arr_wr_state; wrLru = arr_wr_lru;
                wrCount++;
            end
        end
        if (snoop_rsp_valid) begin
            rspVal = snoop_rsp;
            rspCount++;
        end
        if (done) doneCount++;
        if (bus_req) begin
            if (!bus_ack) begin
                if (busWait == 1) begin
                    bus_ack = 1'b1;
                    if (busCount < 64) busLog[busCount] = bus_op;
                    busCount++;
                    busWait = 0;
                end else begin
                    busWait++;
                end
            end
        end else begin
            bus_ack = 1'b0;
            busWait = 0;
        end
    end

    task automatic checkVal(input string name, input int idx, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s (case %0d): actual=%0d required=%0d", name, idx, actual, expected);
        end
    endtask

    int wr0, rsp0, done0, bus0, cyc;
    logic timedOut;

    task automatic applyStimulus(input vec_t v);
        pVec = v;
        preloadSeq++;
        curMiState = v.expMiState; curOpr = v.opr; curMiSnoop = v.expMiSnoopIn;
        curNs = v.miNs; curBop = v.miBop; curSo = v.miSo;
        bus_snoop = v.snoop;
        @(negedge clk);
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        wr0 = wrCount; rsp0 = rspCount; done0 = doneCount; bus0 = busCount;
        cmd_valid = 1'b1; cmd_opr = v.opr; cmd_tag = v.tag; cmd_index = v.idx;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                timedOut = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal("done_seen", idx, int'(timedOut), 0);
        checkVal("latency", idx, cyc, int'(v.expCyc));
        checkVal("done_pulses", idx, doneCount - done0, 1);
        checkVal("writes", idx, wrCount - wr0, int'(v.expWr));
        if (v.expWr && wrCount > wr0) begin
            checkVal("wr_way", idx, int'(wrWay), int'(v.expWay));
            checkVal("wr_tag", idx, int'(wrTag), int'(v.tag));
            checkVal("wr_state", idx, int'(wrState), int'(v.expState));
            checkVal("wr_lru", idx, int'(wrLru), int'(v.expLru));
        end
        checkVal("bus_ops", idx, busCount - bus0, int'(v.expNBus));
        if (v.expNBus >= 2'd1 && busCount > bus0)
            checkVal("bus_op0", idx, int'(busLog[bus0]), int'(v.expBus0));
        if (v.expNBus >= 2'd2 && busCount > bus0 + 1)
            checkVal("bus_op1", idx, int'(busLog[bus0+1]), int'(v.expBus1));
        checkVal("snoop_rsp_valid", idx, rspCount - rsp0, int'(v.expRspV));
        if (v.expRspV && rspCount > rsp0)
            checkVal("snoop_rsp", idx, int'(rspVal), int'(v.expRsp));
    endtask

    localparam int NVEC = 14;
    vec_t vecs [0:NVEC-1];
    int clr0;

    initial begin
        // opr, tag, idx, tags{3..0}, states{3..0}, lru, snoop, miState, miSnoopIn, ns, bop, so,
        // wr, way, state, lru, nbus, bus0, bus1, rspV, rsp, cycles
        vecs[0]  = '{4'd0, 12'h123, 2'd1, {12'h0,12'h0,12'h0,12'h0}, {SI,SI,SI,SI}, 3'b000, 2'd2, SI, 2'd2, SE, 3'd5, 2'd0, 1'b1, 2'd0, SE, 3'b011, 2'd1, 3'd1, 3'd0, 1'b0, 2'd0, 8'd7};
        vecs[1]  = '{4'd0, 12'h123, 2'd1, {12'h0,12'h0,12'h0,12'h123}, {SI,SI,SI,SI}, 3'b000, 2'd0, SI, 2'd0, SF, 3'd5, 2'd0, 1'b1, 2'd0, SF, 3'b011, 2'd1, 3'd1, 3'd0, 1'b0, 2'd0, 8'd7};
        vecs[2]  = '{4'd0, 12'h123, 2'd1, {12'h0,12'h0,12'h0,12'h123}, {SI,SI,SI,SF}, 3'b100, 2'd2, SF, 2'd0, SF, 3'd5, 2'd0, 1'b1, 2'd0, SF, 3'b111, 2'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd4};
        vecs[3]  = '{4'd1, 12'h0AB, 2'd2, {12'h0,12'h0AB,12'h0,12'h0}, {SI,SS,SI,SI}, 3'b000, 2'd2, SS, 2'd0, SM, 3'd4, 2'd0, 1'b1, 2'd2, SM, 3'b100, 2'd1, 3'd4, 3'd0, 1'b0, 2'd0, 8'd7};
        vecs[4]  = '{4'd1, 12'h555, 2'd3, {12'h444,12'h333,12'h222,12'h111}, {SF,SS,SE,SM}, 3'b000, 2'd2, SI, 2'd2, SM, 3'd5, 2'd0, 1'b1, 2'd0, SM, 3'b011, 2'd2, 3'd2, 3'd4, 1'b0, 2'd0, 8'd10};
        vecs[5]  = '{4'd4, 12'h0C3, 2'd0, {12'h0,12'h0,12'h0C3,12'h0}, {SI,SI,SM,SI}, 3'b101, 2'd2, SM, 2'd0, SS, 3'd2, 2'd1, 1'b1, 2'd1, SS, 3'b101, 2'd1, 3'd2, 3'd0, 1'b1, 2'd1, 8'd7};
        vecs[6]  = '{4'd4, 12'h0C3, 2'd0, {12'h0,12'h0,12'h0C3,12'h0}, {SI,SI,SI,SI}, 3'b101, 2'd2, SI, 2'd0, SM, 3'd5, 2'd0, 1'b0, 2'd0, SM, 3'b000, 2'd0, 3'd0, 3'd0, 1'b1, 2'd2, 8'd3};
        vecs[7]  = '{4'd9, 12'h0, 2'd0, {12'h0,12'h0,12'h0,12'h0}, {SI,SI,SI,SI}, 3'b000, 2'd2, SI, 2'd0, SM, 3'd5, 2'd0, 1'b0, 2'd0, SM, 3'b000, 2'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1};
        vecs[8]  = '{4'd7, 12'h0, 2'd0, {12'h0,12'h0,12'h0,12'h0}, {SI,SI,SI,SI}, 3'b000, 2'd2, SI, 2'd0, SM, 3'd5, 2'd0, 1'b0, 2'd0, SM, 3'b000, 2'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1};
        vecs[9]  = '{4'd12, 12'h0, 2'd0, {12'h0,12'h0,12'h0,12'h0}, {SI,SI,SI,SI}, 3'b000, 2'd2, SI, 2'd0, SM, 3'd5, 2'd0, 1'b0, 2'd0, SM, 3'b000, 2'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd1};
        vecs[10] = '{4'd3, 12'h7FF, 2'd1, {12'h7FF,12'h0,12'h0,12'h0}, {SE,SI,SI,SI}, 3'b010, 2'd2, SE, 2'd0, SS, 3'd5, 2'd0, 1'b1, 2'd3, SS, 3'b010, 2'd0, 3'd0, 3'd0, 1'b1, 2'd0, 8'd4};
        vecs[11] = '{4'd0, 12'h0EE, 2'd2, {12'h0EE,12'h011,12'h0EE,12'h022}, {SS,SE,SS,SE}, 3'b000, 2'd2, SS, 2'd0, SS, 3'd5, 2'd0, 1'b1, 2'd1, SS, 3'b001, 2'd0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd4};
        vecs[12] = '{4'd2, 12'h002, 2'd2, {12'h004,12'h000,12'h000,12'h001}, {SS,SI,SI,SS}, 3'b000, 2'd2, SI, 2'd2, SE, 3'd5, 2'd0, 1'b1, 2'd1, SE, 3'b001, 2'd1, 3'd1, 3'd0, 1'b0, 2'd0, 8'd7};
        vecs[13] = '{4'd0, 12'h999, 2'd0, {12'h004,12'h003,12'h002,12'h001}, {SE,SE,SE,SE}, 3'b101, 2'd2, SI, 2'd2, SS, 3'd5, 2'd0, 1'b1, 2'd3, SS, 3'b000, 2'd1, 3'd1, 3'd0, 1'b0, 2'd0, 8'd7};

        // Reset state.
        repeat (2) @(negedge clk);
        checkVal("reset_cmd_ready", -1, int'(cmd_ready), 1);
        checkVal("reset_bus_req", -1, int'(bus_req), 0);
        checkVal("reset_arr_wr_en", -1, int'(arr_wr_en), 0);
        checkVal("reset_arr_rd_en", -1, int'(arr_rd_en), 0);
        checkVal("reset_done", -1, int'(done), 0);
        checkVal("reset_snoop_rsp_valid", -1, int'(snoop_rsp_valid), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Clear: one arr_wr_all per set in address order, done with the last.
        clr0 = clrCount;
        applyStimulus(vecs[7]);
        pVec.opr = 4'd8;
        curOpr = 4'd8;
        @(negedge clk);
        clr0 = clrCount;
        wr0 = wrCount; done0 = doneCount;
        cmd_valid = 1'b1; cmd_opr = 4'd8; cmd_tag = '0; cmd_index = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                timedOut = 1'b0;
                break;
            end
        end
        #1;
        checkVal("clr_done_seen", 100, int'(timedOut), 0);
        checkVal("clr_latency", 100, cyc, 4);
        checkVal("clr_sets", 100, clrCount - clr0, 4);
        for (int a = 0; a < 4; a++)
            if (clrCount - clr0 > a) checkVal("clr_addr", 100 + a, int'(clrAddrs[clr0 + a]), a);
        checkVal("clr_plain_writes", 100, wrCount - wr0, 0);
        checkVal("clr_state_set3_way0", 100, int'(mState[3][0]), int'(SI));
        checkVal("clr_lru_set2", 100, int'(mLru[2]), 0);

        // Reset while a bus request is pending.
        pVec = vecs[0];
        preloadSeq++;
        curMiState = vecs[0].expMiState; curOpr = 4'd0; curMiSnoop = vecs[0].expMiSnoopIn;
        bus_snoop = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opr = 4'd0; cmd_tag = 12'h321; cmd_index = 2'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        timedOut = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkVal("rst_bus_req_seen", 200, int'(timedOut), 0);
        #2 rst_n = 1'b0;
        #1;
        checkVal("rst_bus_req_drop", 200, int'(bus_req), 0);
        checkVal("rst_cmd_ready", 200, int'(cmd_ready), 1);
        checkVal("rst_arr_wr_en", 200, int'(arr_wr_en), 0);
        wr0 = wrCount;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("rst_no_write", 200, wrCount - wr0, 0);

        // The sequencer takes commands normally after the abort.
        applyStimulus(vecs[0]);
        checkOutput(vecs[0], 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
